// File: rtl/tank_motion_if.sv
// Request/response and map-lookup signals between a tank mover and its controller.
// master = the side issuing move requests and answering map lookups; slave = tank_motion_ctrl.
interface tank_motion_if;
    logic       move_req;
    logic [1:0] move_dir;
    logic [7:0] other_tank;
    logic       map_is_wall;
    logic [7:0] map_coord;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [1:0] facing;
    logic       move_ack;
    logic       moved;
    logic       blocked;
    logic       busy;

    modport master (
        output move_req, move_dir, other_tank, map_is_wall,
        input  map_coord, pos_x, pos_y, facing, move_ack, moved, blocked, busy
    );

    modport slave (
        input  move_req, move_dir, other_tank, map_is_wall,
        output map_coord, pos_x, pos_y, facing, move_ack, moved, blocked, busy
    );
endinterface

// File: rtl/tank_motion_ctrl.sv
// Steps one tank across the tile grid: bounds check on request, wall/tank check one
// cycle later through the map lookup, then a cooldown that sets the step rate.
module tank_motion_ctrl #(
    parameter int GRID_MAX      = 12,
    parameter int MOVE_COOLDOWN = 12_500_000,
    parameter int CD_W          = 24,
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int START_DIR     = 0
) (
    input  logic         clk,
    input  logic         reset,
    tank_motion_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, COOLDOWN} state_t;

    localparam logic [3:0]      GMAX    = 4'(GRID_MAX);
    localparam logic [3:0]      SX      = 4'(START_X);
    localparam logic [3:0]      SY      = 4'(START_Y);
    localparam logic [1:0]      SDIR    = 2'(START_DIR);
    localparam bit              NO_CD   = (MOVE_COOLDOWN == 0);
    localparam logic [CD_W-1:0] CD_LOAD = NO_CD ? '0 : CD_W'(MOVE_COOLDOWN - 1);

    state_t          state_q, state_d;
    logic [3:0]      pos_x_q, pos_x_d;
    logic [3:0]      pos_y_q, pos_y_d;
    logic [1:0]      facing_q, facing_d;
    logic [7:0]      map_coord_q, map_coord_d;
    logic [CD_W-1:0] cnt_q, cnt_d;
    logic            moved_q, moved_d;
    logic            blocked_q, blocked_d;
    logic            ack_c;
    logic [3:0]      tgt_x, tgt_y;
    logic            oob;

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        facing_d    = facing_q;
        map_coord_d = map_coord_q;
        cnt_d       = cnt_q;
        moved_d     = 1'b0;
        blocked_d   = 1'b0;
        ack_c       = 1'b0;
        tgt_x       = pos_x_q;
        tgt_y       = pos_y_q;
        oob         = 1'b0;

        case (bus.move_dir)
            2'd0: begin tgt_y = pos_y_q - 4'd1; oob = (pos_y_q == 4'd0); end
            2'd1: begin tgt_y = pos_y_q + 4'd1; oob = (pos_y_q == GMAX); end
            2'd2: begin tgt_x = pos_x_q - 4'd1; oob = (pos_x_q == 4'd0); end
            default: begin tgt_x = pos_x_q + 4'd1; oob = (pos_x_q == GMAX); end
        endcase

        case (state_q)
            IDLE: begin
                if (bus.move_req) begin
                    ack_c    = 1'b1;
                    facing_d = bus.move_dir;
                    if (oob) begin
                        blocked_d = 1'b1;
                    end else begin
                        map_coord_d = {tgt_x, tgt_y};
                        state_d     = CHECK;
                    end
                end
            end
            // map_coord_q is the latched target; the lookup answer is valid this cycle
            CHECK: begin
                if (bus.map_is_wall || (map_coord_q == bus.other_tank)) begin
                    blocked_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    pos_x_d = map_coord_q[7:4];
                    pos_y_d = map_coord_q[3:0];
                    moved_d = 1'b1;
                    if (NO_CD) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CD_LOAD;
                        state_d = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pos_x_q     <= SX;
            pos_y_q     <= SY;
            facing_q    <= SDIR;
            map_coord_q <= {SX, SY};
            cnt_q       <= '0;
            moved_q     <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            facing_q    <= facing_d;
            map_coord_q <= map_coord_d;
            cnt_q       <= cnt_d;
            moved_q     <= moved_d;
            blocked_q   <= blocked_d;
        end
    end

    assign bus.map_coord = map_coord_q;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.facing    = facing_q;
    assign bus.move_ack  = ack_c;
    assign bus.moved     = moved_q;
    assign bus.blocked   = blocked_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Bench for tank_motion_ctrl: scripted moves, expected step outcomes queued at request
// time and matched against moved/blocked pulses by a monitor.
module tb_tank_motion_ctrl;
    localparam int         CD   = 4;
    localparam logic [3:0] GMAX = 4'd12;

    typedef struct {
        logic       mv;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] f;
        logic [7:0] m;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] wall_tile;
    logic [3:0] mx, my;
    logic [1:0] exp_face;
    logic [7:0] exp_map;
    exp_t       q[$];
    int         n_vec;
    int         n_err;

    tank_motion_if bus();

    tank_motion_ctrl #(
        .GRID_MAX(12), .MOVE_COOLDOWN(CD), .CD_W(24),
        .START_X(0), .START_Y(0), .START_DIR(0)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    assign bus.map_is_wall = (bus.map_coord == wall_tile);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every moved/blocked pulse must match the oldest queued outcome.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.moved && bus.blocked) begin
                n_vec++; n_err++;
                $display("FAIL excl: moved and blocked both high");
            end
            if (bus.move_ack && bus.busy) begin
                n_vec++; n_err++;
                $display("FAIL ack_busy: move_ack high while busy");
            end
            if (bus.moved || bus.blocked) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected: moved=%0b blocked=%0b with nothing queued", bus.moved, bus.blocked);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.moved !== e.mv || {bus.pos_x, bus.pos_y} !== {e.x, e.y} ||
                        bus.facing !== e.f || bus.map_coord !== e.m) begin
                        n_err++;
                        $display("FAIL outcome: got mv=%0b pos=(%0d,%0d) f=%0d map=%h, expected mv=%0b pos=(%0d,%0d) f=%0d map=%h",
                                 bus.moved, bus.pos_x, bus.pos_y, bus.facing, bus.map_coord,
                                 e.mv, e.x, e.y, e.f, e.m);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (bus.busy) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: busy=%0b expected 0", bus.busy);
        end
    endtask

    // Present one request, queue its expected outcome, return the outcome class:
    // 0 = committed, 1 = rejected in CHECK, 2 = rejected out of grid.
    task automatic issue(input logic [1:0] dir, output int kind);
        logic [3:0] tx, ty;
        logic       oob;
        exp_t       e;
        wait_idle();
        tx = mx; ty = my; oob = 1'b0;
        case (dir)
            2'd0: begin oob = (my == 4'd0); ty = my - 4'd1; end
            2'd1: begin oob = (my == GMAX); ty = my + 4'd1; end
            2'd2: begin oob = (mx == 4'd0); tx = mx - 4'd1; end
            default: begin oob = (mx == GMAX); tx = mx + 4'd1; end
        endcase
        if (oob) kind = 2;
        else if ({tx, ty} == wall_tile || {tx, ty} == bus.other_tank) kind = 1;
        else kind = 0;
        if (kind != 2) exp_map = {tx, ty};
        if (kind == 0) begin mx = tx; my = ty; end
        exp_face = dir;
        e.mv = (kind == 0); e.x = mx; e.y = my; e.f = dir; e.m = exp_map;
        q.push_back(e);
        bus.move_dir = dir;
        bus.move_req = 1'b1;
        #1;
        n_vec++;
        if (bus.move_ack !== 1'b1) begin
            n_err++;
            $display("FAIL ack: move_ack=%0b expected 1", bus.move_ack);
        end
        @(posedge clk);
        #1;
        bus.move_req = 1'b0;
        n_vec++;
        if (bus.facing !== dir) begin
            n_err++;
            $display("FAIL facing: got %0d expected %0d", bus.facing, dir);
        end
    endtask

    task automatic step(input logic [1:0] dir);
        int kind;
        int n;
        issue(dir, kind);
        @(negedge clk);
        n_vec++;
        if (kind == 2) begin
            if (bus.blocked !== 1'b1 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL oob_timing: blocked=%0b busy=%0b expected 1/0", bus.blocked, bus.busy);
            end
        end else begin
            if (bus.busy !== 1'b1 || bus.moved !== 1'b0 || bus.blocked !== 1'b0) begin
                n_err++;
                $display("FAIL check_cycle: busy=%0b moved=%0b blocked=%0b expected 1/0/0", bus.busy, bus.moved, bus.blocked);
            end
            @(negedge clk);
            n_vec++;
            if (bus.moved !== (kind == 0) || bus.blocked !== (kind == 1)) begin
                n_err++;
                $display("FAIL result_cycle: moved=%0b blocked=%0b expected %0b/%0b", bus.moved, bus.blocked, kind == 0, kind == 1);
            end
            n = 0;
            while (bus.busy && n < 50) begin
                n++;
                @(negedge clk);
            end
            n_vec++;
            if (n != ((kind == 0) ? CD : 0)) begin
                n_err++;
                $display("FAIL cooldown_len: got %0d cycles expected %0d", n, (kind == 0) ? CD : 0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.move_req = 1'b0; bus.move_dir = 2'd0; bus.other_tank = 8'hFF;
        wall_tile = 8'hFF;
        mx = 4'd0; my = 4'd0; exp_face = 2'd0; exp_map = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.pos_x, bus.pos_y, bus.facing, bus.map_coord} !== {4'd0, 4'd0, 2'd0, 8'h00} ||
            {bus.move_ack, bus.moved, bus.blocked, bus.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: pos=(%0d,%0d) f=%0d map=%h ack/mv/blk/busy=%b expected (0,0) 0 00 0000",
                     bus.pos_x, bus.pos_y, bus.facing, bus.map_coord,
                     {bus.move_ack, bus.moved, bus.blocked, bus.busy});
        end
    endtask

    task automatic test_bounds();
        step(2'd2);
        step(2'd0);
        n_vec++;
        if (bus.map_coord !== 8'h00 || bus.facing !== 2'd0) begin
            n_err++;
            $display("FAIL bounds_hold: map=%h f=%0d expected 00 0", bus.map_coord, bus.facing);
        end
    endtask

    task automatic test_first_step();
        step(2'd3);
        n_vec++;
        if (bus.map_coord !== 8'h10 || bus.pos_x !== 4'd1) begin
            n_err++;
            $display("FAIL first_step: map=%h x=%0d expected 10 1", bus.map_coord, bus.pos_x);
        end
    endtask

    task automatic test_wall();
        wall_tile = 8'h20;
        step(2'd3);
        wall_tile = 8'hFF;
        n_vec++;
        if ({bus.pos_x, bus.pos_y} !== 8'h10 || bus.facing !== 2'd3) begin
            n_err++;
            $display("FAIL wall: pos=%h f=%0d expected 10 3", {bus.pos_x, bus.pos_y}, bus.facing);
        end
    endtask

    task automatic test_tank();
        repeat (4) step(2'd3);
        repeat (5) step(2'd1);
        bus.other_tank = 8'h56;
        step(2'd1);
        bus.other_tank = 8'h99;
        step(2'd1);
        bus.other_tank = 8'hFF;
        n_vec++;
        if ({bus.pos_x, bus.pos_y} !== 8'h56) begin
            n_err++;
            $display("FAIL tank: pos=%h expected 56", {bus.pos_x, bus.pos_y});
        end
    endtask

    task automatic test_back_to_back();
        int   cyc, last, cnt;
        exp_t e;
        repeat (2) step(2'd2);
        repeat (3) step(2'd0);
        wait_idle();
        for (int y = 4; y <= 12; y++) begin
            e.mv = 1'b1; e.x = 4'd3; e.y = 4'(y); e.f = 2'd1; e.m = {4'd3, 4'(y)};
            q.push_back(e);
        end
        e.mv = 1'b0; e.x = 4'd3; e.y = 4'd12; e.f = 2'd1; e.m = 8'h3C;
        q.push_back(e);
        bus.move_dir = 2'd1;
        bus.move_req = 1'b1;
        cyc = 0; last = -1; cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.moved) begin
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last != CD + 2) begin
                        n_err++;
                        $display("FAIL step_rate: got %0d cycles expected %0d", cyc - last, CD + 2);
                    end
                end
                last = cyc;
                cnt++;
            end
            if (bus.blocked) break;
        end
        bus.move_req = 1'b0;
        mx = 4'd3; my = 4'd12; exp_face = 2'd1; exp_map = 8'h3C;
        n_vec++;
        if (cnt != 9 || bus.blocked !== 1'b1) begin
            n_err++;
            $display("FAIL hold_run: got %0d steps blocked=%0b expected 9 1", cnt, bus.blocked);
        end
    endtask

    task automatic test_reset_mid();
        int kind;
        issue(2'd0, kind);
        rst = 1'b1;
        #1;
        q.delete();
        n_vec++;
        if (bus.busy !== 1'b0 || {bus.pos_x, bus.pos_y} !== 8'h00 || bus.facing !== 2'd0 || bus.map_coord !== 8'h00) begin
            n_err++;
            $display("FAIL rst_check: busy=%0b pos=%h f=%0d map=%h expected 0 00 0 00",
                     bus.busy, {bus.pos_x, bus.pos_y}, bus.facing, bus.map_coord);
        end
        mx = 4'd0; my = 4'd0; exp_face = 2'd0; exp_map = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        step(2'd3);
        issue(2'd1, kind);
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b1 || q.size() != 0) begin
            n_err++;
            $display("FAIL in_cooldown: busy=%0b queued=%0d expected 1 0", bus.busy, q.size());
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || {bus.pos_x, bus.pos_y} !== 8'h00) begin
            n_err++;
            $display("FAIL rst_cooldown: busy=%0b pos=%h expected 0 00", bus.busy, {bus.pos_x, bus.pos_y});
        end
        mx = 4'd0; my = 4'd0; exp_face = 2'd0; exp_map = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        step(2'd1);
        n_vec++;
        if ({bus.pos_x, bus.pos_y} !== 8'h01) begin
            n_err++;
            $display("FAIL after_reset: pos=%h expected 01", {bus.pos_x, bus.pos_y});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_bounds();
        test_first_step();
        test_wall();
        test_tank();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d outcomes never observed", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
